cnu_serial: RTL and testbench
=============================

Name: cnu_serial

Overview:
- Serial offset min-sum check node unit that consumes the extended-width variable-to-check messages produced by the VNU, one edge per cycle.
- Once all DC messages of a check row are collected, it emits the DC check-to-variable messages (data_w wide) back to the VNUs, one per cycle.
- It also emits the row's parity-check result.

Parameters:
- data_w, 6, width of the two's-complement output message r_out.
- ext_w, 3, extra width of input messages; input width sum_w = data_w + ext_w.
- DC, 6, check node degree (edges per row), minimum 2.
- idx_w, 3, width of edge index; must satisfy 2^idx_w >= DC.
- OFS, 0, offset subtracted from output magnitude (unsigned, < 2^(data_w-1)).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  q_in valid.
- in_ready  output  1  block accepts q_in this cycle.
- q_in  input  sum_w  two's-complement variable-to-check message for current edge.
- out_valid  output  1  r_out valid.
- out_ready  input  1  downstream accepts r_out.
- r_out  output  data_w  two's-complement check-to-variable message.
- out_idx  output  idx_w  edge index (0..DC-1) of r_out.
- parity_ok  output  1  1 = XOR of all input hard decisions is 0.

Behaviour:
- Reset (async, rst_n low):
  - state COLLECT, cnt=0, in_ready=1 after release, out_valid=0, r_out=0, out_idx=0, parity_ok=0.
  - min1=min2=MAXM, where MAXM=2^(data_w-1)-1. idx1=0, sign_acc=0, sign store=0.
- FSM states:
  - COLLECT: in_ready=1, out_valid=0.
    - Accept on in_valid&in_ready; edges arrive in order 0..DC-1 and edge number = cnt.
    - cnt increments per accept.
    - On the accept with cnt==DC-1: cnt<=0, go to EMIT next cycle.
  - EMIT: in_ready=0 (q_in ignored), out_valid=1, out_idx=cnt, r_out = message for edge cnt.
    - On out_valid&out_ready, cnt increments.
    - On the handshake with cnt==DC-1: return to COLLECT, re-init min1/min2/idx1/sign_acc. No overlap between rows.
- Latency: out_valid rises the cycle after the last input accept. Row throughput is 2*DC cycles with no backpressure.
- Per-accept arithmetic:
  - sgn = q_in[sum_w-1], so negative means hard decision 1 and zero counts as positive.
  - mag = min(|q_in|, MAXM). |-2^(sum_w-1)| saturates to MAXM with no overflow.
  - sign store[cnt] <= sgn; sign_acc ^= sgn.
  - If mag < min1: min2<=min1, min1<=mag, idx1<=cnt.
  - Else if mag < min2: min2<=mag.
  - Comparisons are strict, so on ties idx1 keeps the first occurrence and an equal later value lands in min2.
- Output for edge k:
  - m = (k==idx1) ? min2 : min1.
  - m' = (m > OFS) ? m-OFS : 0.
  - s = sign_acc ^ store[k].
  - r_out = s ? -m' : m'. A zero magnitude always gives r_out=0 (no negative zero). Range is ±MAXM.
- Output stability: r_out/out_idx are registered or derived from registered state only, and held stable while out_valid & !out_ready.
- parity_ok:
  - Loaded with ~sign_acc_final on the COLLECT→EMIT transition.
  - Held until the next such transition. It is valid throughout EMIT.
- Reset mid-operation: any partial row is discarded; the next row after release starts at edge 0.
- in_valid with in_ready=0 has no effect.

Test Plan (data_w=6, ext_w=3, DC=6, OFS=0 unless stated):
1. q_in = 5,-3,7,10,-20,4 back-to-back, out_ready=1 -> r_out = +3,-4,+3,+3,-3,+3 at idx 0..5; parity_ok=1; out_valid first high the cycle after 6th accept.
2. Saturation: q_in = -256,255,100,40,31,32 -> all magnitudes 31, sign_acc=1; r_out = +31,-31,-31,-31,-31,-31; parity_ok=0.
3. Ties: q_in = 2,2,-2,9,9,9 -> min1=min2=2, idx1=0; r_out = -2,-2,+2,-2,-2,-2; parity_ok=0.
4. Backpressure and gaps:
   - Stimulus: in_valid gaps of 1-2 cycles during COLLECT; out_ready low 3 cycles at idx 2; q_in driven with in_valid=1 during EMIT.
   - Required: same results as scenario 1; r_out/out_idx stable while stalled; in_ready=0 during EMIT; q_in driven during EMIT is ignored.
5. Reset mid-row: assert rst_n low after EMIT handshake at idx 3 -> out_valid=0, r_out=0, parity_ok=0 immediately; after release in_ready=1 and the next row (scenario 2 data) produces exact scenario 2 results.
6. OFS=1, q_in = 0,1,-1,6,6,6 -> min1=0, min2=1 (idx1=0), sign_acc=1; r_out = 0,0,0,0,0,0 after offset clamp; parity_ok=0.

Source files
------------

// File: rtl/cnu_serial.sv
// Serial offset min-sum check node unit: collects DC variable-to-check messages
// one per cycle, then emits DC check-to-variable messages plus the row parity result.
//
// state   | meaning
// COLLECT | accepting q_in for edges 0..DC-1, tracking min1/min2/idx1/signs
// EMIT    | presenting r_out for edge cnt, advancing on out_ready
module cnu_serial #(
   parameter int data_w = 6,
   parameter int ext_w  = 3,
   parameter int DC     = 6,
   parameter int idx_w  = 3,
   parameter int OFS    = 0
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [data_w+ext_w-1:0]   q_in,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [data_w-1:0]         r_out,
   output logic [idx_w-1:0]          out_idx,
   output logic                      parity_ok
);

   localparam int sum_w = data_w + ext_w;
   localparam int mag_w = data_w - 1;
   localparam logic [mag_w-1:0] MAXM  = {mag_w{1'b1}};
   localparam logic [mag_w-1:0] OFS_M = mag_w'(OFS);
   localparam logic [idx_w-1:0] LAST  = idx_w'(DC - 1);

   typedef enum logic {COLLECT = 1'b0, EMIT = 1'b1} state_t;

   state_t              state;
   logic [idx_w-1:0]    cnt;
   logic [mag_w-1:0]    min1;
   logic [mag_w-1:0]    min2;
   logic [idx_w-1:0]    idx1;
   logic                sign_acc;
   logic [DC-1:0]       sgn_store;

   logic                accept;
   logic                fire;
   logic                sgn;
   logic [sum_w-1:0]    abs_q;
   logic [mag_w-1:0]    mag;

   assign accept = in_valid & in_ready;
   assign fire   = out_valid & out_ready;

   // Two's-complement abs of the most negative value wraps to 2^(sum_w-1) as
   // an unsigned quantity, which the saturation below clamps to MAXM.
   assign sgn   = q_in[sum_w-1];
   assign abs_q = sgn ? (~q_in + sum_w'(1)) : q_in;
   assign mag   = (abs_q > sum_w'(MAXM)) ? MAXM : abs_q[mag_w-1:0];

   logic [mag_w-1:0]    m_sel;
   logic [mag_w-1:0]    m_ofs;
   logic                s_out;
   logic [data_w-1:0]   r_mag;

   assign m_sel = (cnt == idx1) ? min2 : min1;
   assign m_ofs = (m_sel > OFS_M) ? (m_sel - OFS_M) : '0;
   assign s_out = sign_acc ^ sgn_store[cnt];
   assign r_mag = {1'b0, m_ofs};

   // Outputs derive only from registered state, so they hold during stalls.
   assign r_out   = (state == EMIT) ? (s_out ? -r_mag : r_mag) : '0;
   assign out_idx = (state == EMIT) ? cnt : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= COLLECT;
         cnt       <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         parity_ok <= 1'b0;
         min1      <= MAXM;
         min2      <= MAXM;
         idx1      <= '0;
         sign_acc  <= 1'b0;
         sgn_store <= '0;
      end else begin
         case (state)
            COLLECT: begin
               if (accept) begin
                  sgn_store[cnt] <= sgn;
                  sign_acc       <= sign_acc ^ sgn;
                  if (mag < min1) begin
                     min2 <= min1;
                     min1 <= mag;
                     idx1 <= cnt;
                  end else if (mag < min2) begin
                     min2 <= mag;
                  end
                  if (cnt == LAST) begin
                     cnt       <= '0;
                     state     <= EMIT;
                     in_ready  <= 1'b0;
                     out_valid <= 1'b1;
                     parity_ok <= ~(sign_acc ^ sgn);
                  end else begin
                     cnt <= cnt + idx_w'(1);
                  end
               end
            end
            EMIT: begin
               if (fire) begin
                  if (cnt == LAST) begin
                     cnt       <= '0;
                     state     <= COLLECT;
                     in_ready  <= 1'b1;
                     out_valid <= 1'b0;
                     min1      <= MAXM;
                     min2      <= MAXM;
                     idx1      <= '0;
                     sign_acc  <= 1'b0;
                  end else begin
                     cnt <= cnt + idx_w'(1);
                  end
               end
            end
            default: state <= COLLECT;
         endcase
      end
   end

endmodule

// File: tb/tb_cnu_serial.sv
// Directed bench for cnu_serial: two instances (OFS=0 and OFS=1) share stimulus
// so the offset case reuses the same row driver.
module tb_cnu_serial;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic [8:0]  q_in = '0;
   logic        out_ready = 1'b1;

   logic        in_ready0, out_valid0, parity_ok0;
   logic [5:0]  r_out0;
   logic [2:0]  out_idx0;
   logic        in_ready1, out_valid1, parity_ok1;
   logic [5:0]  r_out1;
   logic [2:0]  out_idx1;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   cnu_serial #(.data_w(6), .ext_w(3), .DC(6), .idx_w(3), .OFS(0)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
      .q_in(q_in), .out_valid(out_valid0), .out_ready(out_ready),
      .r_out(r_out0), .out_idx(out_idx0), .parity_ok(parity_ok0)
   );

   cnu_serial #(.data_w(6), .ext_w(3), .DC(6), .idx_w(3), .OFS(1)) u_ofs (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
      .q_in(q_in), .out_valid(out_valid1), .out_ready(out_ready),
      .r_out(r_out1), .out_idx(out_idx1), .parity_ok(parity_ok1)
   );

   task automatic chk(input string tag, input logic signed [31:0] obs,
                      input logic signed [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic signed [31:0] robs(input bit ofs);
      return ofs ? 32'($signed(r_out1)) : 32'($signed(r_out0));
   endfunction

   task automatic feed(input int v[6], input bit gaps);
      for (int i = 0; i < 6; i++) begin
         if (gaps) begin
            in_valid = 1'b0;
            q_in = 9'h0FF;
            repeat ((i % 2) + 1) begin
               @(posedge clk); #1;
            end
         end
         chk("in_ready_collect", in_ready0, 1);
         chk("out_valid_collect", out_valid0, 0);
         in_valid = 1'b1;
         q_in = 9'(v[i]);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      chk("out_valid_latency", out_valid0, 1);
      chk("in_ready_emit", in_ready0, 0);
   endtask

   task automatic drain(input int e[6], input bit ofs, input int n,
                        input int stall_at, input bit junk);
      out_ready = 1'b1;
      if (junk) begin
         in_valid = 1'b1;
         q_in = 9'h1AA;
      end
      for (int k = 0; k < n; k++) begin
         if (k == stall_at) begin
            out_ready = 1'b0;
            for (int c = 0; c < 3; c++) begin
               @(posedge clk); #1;
               chk("stall_idx", out_idx0, k);
               chk("stall_r_out", robs(ofs), e[k]);
               chk("stall_valid", out_valid0, 1);
               chk("stall_in_ready", in_ready0, 0);
            end
            out_ready = 1'b1;
         end
         chk("out_idx", ofs ? out_idx1 : out_idx0, k);
         chk("r_out", robs(ofs), e[k]);
         chk("out_valid", out_valid0, 1);
         if (junk) chk("in_ready_junk", in_ready0, 0);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int v1[6] = '{5, -3, 7, 10, -20, 4};
      int e1[6] = '{3, -4, 3, 3, -3, 3};
      int v2[6] = '{-256, 255, 100, 40, 31, 32};
      int e2[6] = '{31, -31, -31, -31, -31, -31};
      int v3[6] = '{2, 2, -2, 9, 9, 9};
      int e3[6] = '{-2, -2, 2, -2, -2, -2};
      int v6[6] = '{0, 1, -1, 6, 6, 6};
      int e6[6] = '{0, 0, 0, 0, 0, 0};

      #12;
      chk("rst_out_valid", out_valid0, 0);
      chk("rst_r_out", robs(0), 0);
      chk("rst_out_idx", out_idx0, 0);
      chk("rst_parity", parity_ok0, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rst_in_ready", in_ready0, 1);

      // basic row
      feed(v1, 0);
      chk("s1_parity", parity_ok0, 1);
      drain(e1, 0, 6, -1, 0);
      chk("s1_done_valid", out_valid0, 0);
      chk("s1_done_ready", in_ready0, 1);

      // saturation
      feed(v2, 0);
      chk("s2_parity", parity_ok0, 0);
      drain(e2, 0, 6, -1, 0);

      // ties
      feed(v3, 0);
      chk("s3_parity", parity_ok0, 0);
      drain(e3, 0, 6, -1, 0);

      // gaps, backpressure, junk input during emit
      feed(v1, 1);
      chk("s4_parity", parity_ok0, 1);
      drain(e1, 0, 6, 2, 1);
      chk("s4_done_ready", in_ready0, 1);

      // reset mid-emit after the idx 3 handshake
      feed(v1, 0);
      drain(e1, 0, 4, -1, 0);
      rst_n = 1'b0;
      #1;
      chk("s5_rst_valid", out_valid0, 0);
      chk("s5_rst_r_out", robs(0), 0);
      chk("s5_rst_parity", parity_ok0, 0);
      chk("s5_rst_idx", out_idx0, 0);
      #2;
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("s5_in_ready", in_ready0, 1);
      feed(v2, 0);
      chk("s5_parity", parity_ok0, 0);
      drain(e2, 0, 6, -1, 0);

      // offset instance
      feed(v6, 0);
      chk("s6_parity", parity_ok1, 0);
      drain(e6, 1, 6, -1, 0);
      chk("s6_done_valid", out_valid1, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
